pc_fetch_unit: RTL and testbench

Parametrised successor to the combinational next-PC selector. Owns the architectural fetch PC register and drives the instruction-fetch handshake. Resolves branch/jal/jalr redirects from the execute stage and applies trap redirects and misaligned-target detection. Keeps a saturating redirect counter. Sits between the execute stage (redirect inputs) and instruction memory (fetch handshake).

---
 rtl/pc_fetch_unit_pkg.sv | 17 +
 rtl/pc_fetch_unit_if.sv | 13 +
 rtl/npc_target_calc.sv | 31 +++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch PC unit: pc_sel encodings, FSM states, reset vector.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JAL    = 2'b10;
  localparam logic [1:0] PC_SEL_JALR   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    EXC  = 2'b10
  } state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch request handshake between the fetch unit and instruction memory.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;

  modport master (output fetch_valid, output pc, input fetch_ready);
  modport slave  (input fetch_valid, input pc, output fetch_ready);

endinterface

// File: rtl/npc_target_calc.sv
// Combinational redirect target, take decision and misaligned-target detection.
module npc_target_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic            redir_valid,
  input  logic [1:0]      pc_sel,
  input  logic            alu_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] sext,
  input  logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] target_c,
  output logic            take_c,
  output logic            misalign_c
);

  always_comb begin
    target_c = ex_pc + sext;
    if (pc_sel == PC_SEL_JALR) begin
      target_c    = rD1 + sext;
      target_c[0] = 1'b0;
    end
    take_c = redir_valid & ((pc_sel == PC_SEL_JAL) | (pc_sel == PC_SEL_JALR) |
                            ((pc_sel == PC_SEL_BRANCH) & alu_branch));
    // bit 0 is never considered; only 32-bit alignment can misalign
    misalign_c = (IALIGN == 32) && target_c[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and FSM: sequential advance, branch/jump/trap redirects, misalign trap.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     ILEN_BYTES   = 4,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  pc_fetch_unit_if.master   fetch,
  input  logic              redir_valid,
  input  logic [1:0]        pc_sel,
  input  logic              alu_branch,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   sext,
  input  logic [XLEN-1:0]   rD1,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_target,
  output logic              flush,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  redir_count
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              fetch_valid_q;
  logic              flush_d;
  logic              misalign_exc_d;
  logic [XLEN-1:0]   misalign_addr_d;
  logic [CNT_W-1:0]  redir_count_d;

  logic [XLEN-1:0]   target_c;
  logic              take_c;
  logic              misalign_c;

  npc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target (
    .redir_valid (redir_valid),
    .pc_sel      (pc_sel),
    .alu_branch  (alu_branch),
    .ex_pc       (ex_pc),
    .sext        (sext),
    .rD1         (rD1),
    .target_c    (target_c),
    .take_c      (take_c),
    .misalign_c  (misalign_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      flush         <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
      redir_count   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == RUN);
      flush         <= flush_d;
      misalign_exc  <= misalign_exc_d;
      misalign_addr <= misalign_addr_d;
      redir_count   <= redir_count_d;
    end
  end

  // Priority: trap > misaligned redirect > redirect > hold > sequential advance
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    flush_d         = 1'b0;
    misalign_exc_d  = misalign_exc;
    misalign_addr_d = misalign_addr;
    redir_count_d   = redir_count;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, EXC: begin
        if (trap_valid) begin
          pc_d           = trap_target;
          flush_d        = 1'b1;
          state_d        = RUN;
          misalign_exc_d = 1'b0;
        end else if (state_q == RUN) begin
          if (take_c && misalign_c) begin
            state_d         = EXC;
            misalign_exc_d  = 1'b1;
            misalign_addr_d = target_c;
            flush_d         = 1'b1;
          end else if (take_c) begin
            pc_d    = target_c;
            flush_d = 1'b1;
            if (redir_count != {CNT_W{1'b1}}) redir_count_d = redir_count + CNT_W'(1);
          end else if (!stall && fetch.fetch_ready) begin
            pc_d = pc_q + XLEN'(ILEN_BYTES);
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign fetch.pc          = pc_q;
  assign fetch.fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench: directed plan scenarios plus randomized traffic against a cycle model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic        alu_branch = 1'b0;
  logic [31:0] ex_pc = '0, sext = '0, rD1 = '0, trap_target = '0;
  logic        trap_valid = 1'b0;
  logic        flush, misalign_exc;
  logic [31:0] misalign_addr;
  logic [1:0]  redir_count;

  int checks = 0;
  int failures = 0;

  // model state: mode 0=boot, 1=run, 2=exception
  int          m_mode;
  logic [31:0] m_pc, m_addr;
  bit          m_flush, m_exc;
  int          m_cnt;

  pc_fetch_unit_if #(.XLEN(32)) fif ();

  pc_fetch_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32), .ILEN_BYTES(4), .CNT_W(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .fetch         (fif),
    .redir_valid   (redir_valid),
    .pc_sel        (pc_sel),
    .alu_branch    (alu_branch),
    .ex_pc         (ex_pc),
    .sext          (sext),
    .rD1           (rD1),
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .flush         (flush),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr),
    .redir_count   (redir_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pc", fif.pc, m_pc);
    check("fetch_valid", 32'(fif.fetch_valid), 32'(m_mode == 1));
    check("flush", 32'(flush), 32'(m_flush));
    check("misalign_exc", 32'(misalign_exc), 32'(m_exc));
    check("misalign_addr", misalign_addr, m_addr);
    check("redir_count", 32'(redir_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_addr = 32'h0; m_flush = 0; m_exc = 0; m_cnt = 0;
  endtask

  // Compute next model state from current inputs, clock once, then compare.
  task automatic cycle();
    logic [31:0] tgt, n_pc, n_addr;
    bit take, mis, n_flush, n_exc;
    int n_mode, n_cnt;
    tgt  = (pc_sel == 2'd3) ? ((rD1 + sext) & ~32'h1) : (ex_pc + sext);
    take = redir_valid && (pc_sel == 2'd2 || pc_sel == 2'd3 || (pc_sel == 2'd1 && alu_branch));
    mis  = tgt[1];
    n_mode = m_mode; n_pc = m_pc; n_addr = m_addr; n_exc = m_exc; n_cnt = m_cnt; n_flush = 0;
    if (m_mode == 0) begin
      n_mode = 1;
    end else if (trap_valid) begin
      n_pc = trap_target; n_flush = 1; n_mode = 1; n_exc = 0;
    end else if (m_mode == 2) begin
      n_mode = 2;
    end else if (take && mis) begin
      n_mode = 2; n_exc = 1; n_addr = tgt; n_flush = 1;
    end else if (take) begin
      n_pc = tgt; n_flush = 1; n_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
    end else if (!stall && fif.fetch_ready) begin
      n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_addr = n_addr; m_exc = n_exc; m_cnt = n_cnt; m_flush = n_flush;
    compare_all();
  endtask

  // Assert reset between edges; state must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    redir_valid = 0; trap_valid = 0; stall = 0; alu_branch = 0; pc_sel = 2'b00;
  endtask

  initial begin
    fif.fetch_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    compare_all();
    check("rst_pc", fif.pc, 32'h0);
    check("rst_fv", 32'(fif.fetch_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot then sequential fetch
    cycle(); check("boot_pc", fif.pc, 32'h0); check("run_fv", 32'(fif.fetch_valid), 32'h1);
    cycle(); check("seq_pc4", fif.pc, 32'h4);
    cycle(); check("seq_pc8", fif.pc, 32'h8); check("cnt0", 32'(redir_count), 32'h0);

    // Taken and not-taken branch
    redir_valid = 1; pc_sel = 2'b01; alu_branch = 1; ex_pc = 32'h100; sext = 32'h20;
    cycle(); check("br_pc", fif.pc, 32'h120); check("br_flush", 32'(flush), 32'h1);
    check("br_cnt", 32'(redir_count), 32'h1);
    redir_valid = 0;
    cycle(); check("br_flush_end", 32'(flush), 32'h0); check("br_seq", fif.pc, 32'h124);
    redir_valid = 1; alu_branch = 0;
    cycle(); check("nt_pc", fif.pc, 32'h128); check("nt_flush", 32'(flush), 32'h0);

    // Misaligned jalr, then trap out of EXC
    pc_sel = 2'b11; rD1 = 32'h203; sext = 32'h0;
    cycle(); check("mis_exc", 32'(misalign_exc), 32'h1); check("mis_addr", misalign_addr, 32'h202);
    check("mis_pc", fif.pc, 32'h128); check("mis_fv", 32'(fif.fetch_valid), 32'h0);
    cycle(); check("exc_hold_pc", fif.pc, 32'h128);
    redir_valid = 0; trap_valid = 1; trap_target = 32'h80;
    cycle(); check("trap_pc", fif.pc, 32'h80); check("trap_exc", 32'(misalign_exc), 32'h0);

    // Back-pressure with coincident jal target, then trap vs jal
    trap_target = 32'h40;
    cycle();
    trap_valid = 0; fif.fetch_ready = 0;
    cycle(); check("bp_pc", fif.pc, 32'h40);
    redir_valid = 1; pc_sel = 2'b10; ex_pc = 32'h30; sext = 32'h10;
    cycle(); check("bp_jal_pc", fif.pc, 32'h40); check("bp_jal_flush", 32'(flush), 32'h1);
    redir_valid = 0;
    cycle(); check("bp_pc3", fif.pc, 32'h40);
    redir_valid = 1; trap_valid = 1; trap_target = 32'h500;
    cycle(); check("trap_wins", fif.pc, 32'h500);
    idle_inputs(); fif.fetch_ready = 1;

    // Counter saturation
    sext = 32'h0; pc_sel = 2'b10; redir_valid = 1;
    for (int i = 0; i < 5; i++) begin
      ex_pc = 32'h200 + 32'(i) * 32'h10;
      cycle();
    end
    check("cnt_sat", 32'(redir_count), 32'h3);

    // Async reset mid-stall
    idle_inputs(); trap_valid = 1; trap_target = 32'h1000;
    cycle();
    trap_valid = 0; stall = 1;
    cycle(); check("stall_pc", fif.pc, 32'h1000);
    async_reset();
    check("arst_pc", fif.pc, 32'h0); check("arst_fv", 32'(fif.fetch_valid), 32'h0);
    idle_inputs();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      redir_valid     = ($urandom_range(0, 99) < 30);
      trap_valid      = ($urandom_range(0, 99) < 6);
      stall           = ($urandom_range(0, 99) < 20);
      fif.fetch_ready = ($urandom_range(0, 99) < 75);
      alu_branch      = 1'($urandom);
      pc_sel          = 2'($urandom);
      ex_pc           = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
      sext            = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 255)) :
                                                      32'($urandom_range(0, 255)) << 2;
      rD1             = $urandom;
      trap_target     = $urandom & ~32'h3;
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
